// File: rtl/power_controller.sv
// Push-button engine power controller: synchronized, debounced buttons feed a
// four-state FSM (off, arming with blinking LED, on, wait-for-release).
module power_controller #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int BLINK_CYCLES    = 12_500_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [1:0] global_state,
  input  logic       power_on,
  input  logic       power_off,
  input  logic       manual_power,
  output logic       next_power,
  output logic       power_light,
  output logic       arming
);

  localparam int DB_W    = ($clog2(DEBOUNCE_CYCLES + 1) > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int HOLD_W  = ($clog2(HOLD_CYCLES + 1) > 27) ? $clog2(HOLD_CYCLES + 1) : 27;
  localparam int BLINK_W = ($clog2(BLINK_CYCLES + 1) > 24) ? $clog2(BLINK_CYCLES + 1) : 24;

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF          = 2'b00,
    ST_ARMING       = 2'b01,
    ST_ON           = 2'b10,
    ST_WAIT_RELEASE = 2'b11
  } state_t;

  logic [1:0] btn_raw;
  logic [1:0] btn_db;
  logic       on_db;
  logic       off_db;

  assign btn_raw = {power_off, power_on};
  assign on_db   = btn_db[0];
  assign off_db  = btn_db[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [1:0]      sync_q, sync_d;
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            level_q, level_d;

      // Any cycle where the synchronized level matches the accepted one restarts the count.
      always_comb begin
        sync_d  = {sync_q[0], btn_raw[gi]};
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
          if (cnt_q == DB_LAST) begin
            level_d = sync_q[1];
          end else begin
            cnt_d = cnt_q + DB_W'(1);
          end
        end
      end

      always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
          sync_q  <= '0;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end else begin
          sync_q  <= sync_d;
          cnt_q   <= cnt_d;
          level_q <= level_d;
        end
      end

      assign btn_db[gi] = level_q;
    end
  endgenerate

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               off_prev_q, off_prev_d;
  logic               light_q, light_d;
  logic               next_power_q, next_power_d;
  logic               arming_q, arming_d;
  logic               off_rise;

  assign off_rise = off_db && !off_prev_q;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    off_prev_d = off_db;
    case (state_q)
      ST_OFF: begin
        if (on_db && !off_db) begin
          state_d = ST_ARMING;
          hold_d  = '0;
        end
      end
      ST_ARMING: begin
        if (off_db) begin
          state_d = ST_WAIT_RELEASE;
        end else if (!on_db) begin
          state_d = ST_OFF;
        end else if (hold_q >= HOLD_LAST) begin
          state_d = ST_ON;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_ON: begin
        if (off_rise || (global_state == 2'b00 && !manual_power)) begin
          state_d = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!on_db) begin
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase

    // The LED starts lit on entry to arming and flips every BLINK_CYCLES after that.
    blink_d = '0;
    light_d = (state_d == ST_ON);
    if (state_d == ST_ARMING) begin
      if (state_q != ST_ARMING) begin
        light_d = 1'b1;
      end else if (blink_q == BLINK_LAST) begin
        light_d = !light_q;
      end else begin
        light_d = light_q;
        blink_d = blink_q + BLINK_W'(1);
      end
    end

    next_power_d = (state_d == ST_ON);
    arming_d     = (state_d == ST_ARMING);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_OFF;
      hold_q       <= '0;
      blink_q      <= '0;
      off_prev_q   <= 1'b0;
      light_q      <= 1'b0;
      next_power_q <= 1'b0;
      arming_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      blink_q      <= blink_d;
      off_prev_q   <= off_prev_d;
      light_q      <= light_d;
      next_power_q <= next_power_d;
      arming_q     <= arming_d;
    end
  end

  assign next_power  = next_power_q;
  assign power_light = light_q;
  assign arming      = arming_q;

endmodule

// File: tb/tb_power_controller.sv
// Directed bench for power_controller with shortened debounce/hold/blink timing.
module tb_power_controller;

  logic       sys_clk;
  logic       rst;
  logic [1:0] global_state;
  logic       power_on;
  logic       power_off;
  logic       manual_power;
  logic       next_power;
  logic       power_light;
  logic       arming;

  int tests_run = 0;
  int tests_failed = 0;

  power_controller #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .BLINK_CYCLES   (3)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .global_state(global_state),
    .power_on    (power_on),
    .power_off   (power_off),
    .manual_power(manual_power),
    .next_power  (next_power),
    .power_light (power_light),
    .arming      (arming)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       po;
    logic       pf;
    logic       mp;
    logic [1:0] gs;
    int         cycles;
    logic       np;
    logic       pl;
    logic       ar;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(logic po, logic pf, logic mp, logic [1:0] gs, int cycles,
                              logic np, logic pl, logic ar);
    vec_t v;
    v.po = po; v.pf = pf; v.mp = mp; v.gs = gs; v.cycles = cycles;
    v.np = np; v.pl = pl; v.ar = ar;
    return v;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      power_on     = vecs[i].po;
      power_off    = vecs[i].pf;
      manual_power = vecs[i].mp;
      global_state = vecs[i].gs;
      repeat (vecs[i].cycles) step();
      check($sformatf("vec%0d next_power", i), next_power, vecs[i].np);
      check($sformatf("vec%0d power_light", i), power_light, vecs[i].pl);
      check($sformatf("vec%0d arming", i), arming, vecs[i].ar);
      $display("[TB] vec%0d po=%b pf=%b mp=%b gs=%b x%0d -> np=%b pl=%b ar=%b",
               i, vecs[i].po, vecs[i].pf, vecs[i].mp, vecs[i].gs, vecs[i].cycles,
               next_power, power_light, arming);
    end
  endtask

  initial begin
    logic seen;

    //            po    pf    mp    gs     n   np    pl    ar
    vecs[0]  = mk(1'b0, 1'b0, 1'b1, 2'b00, 3,  1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b1, 2'b00, 6,  1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b1, 2'b00, 1,  1'b0, 1'b1, 1'b1);
    vecs[3]  = mk(1'b1, 1'b0, 1'b1, 2'b00, 2,  1'b0, 1'b1, 1'b1);
    vecs[4]  = mk(1'b1, 1'b0, 1'b1, 2'b00, 1,  1'b0, 1'b0, 1'b1);
    vecs[5]  = mk(1'b1, 1'b0, 1'b1, 2'b00, 3,  1'b0, 1'b1, 1'b1);
    vecs[6]  = mk(1'b1, 1'b0, 1'b1, 2'b00, 13, 1'b0, 1'b1, 1'b1);
    vecs[7]  = mk(1'b1, 1'b0, 1'b1, 2'b00, 1,  1'b1, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, 2'b00, 10, 1'b1, 1'b1, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 2'b11, 1,  1'b1, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 2'b11, 2,  1'b1, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 2'b00, 1,  1'b0, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b1, 2'b00, 3,  1'b0, 1'b0, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 1'b1, 2'b00, 7,  1'b0, 1'b1, 1'b1);
    vecs[14] = mk(1'b1, 1'b0, 1'b1, 2'b00, 3,  1'b0, 1'b0, 1'b1);
    vecs[15] = mk(1'b0, 1'b0, 1'b1, 2'b00, 6,  1'b0, 1'b0, 1'b1);
    vecs[16] = mk(1'b0, 1'b0, 1'b1, 2'b00, 1,  1'b0, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 1'b1, 2'b00, 5,  1'b0, 1'b0, 1'b0);
    vecs[18] = mk(1'b1, 1'b0, 1'b1, 2'b00, 27, 1'b1, 1'b1, 1'b0);
    vecs[19] = mk(1'b1, 1'b1, 1'b1, 2'b00, 6,  1'b1, 1'b1, 1'b0);
    vecs[20] = mk(1'b1, 1'b1, 1'b1, 2'b00, 1,  1'b0, 1'b0, 1'b0);
    vecs[21] = mk(1'b1, 1'b0, 1'b1, 2'b00, 20, 1'b0, 1'b0, 1'b0);
    vecs[22] = mk(1'b0, 1'b0, 1'b1, 2'b00, 7,  1'b0, 1'b0, 1'b0);
    vecs[23] = mk(1'b1, 1'b0, 1'b1, 2'b00, 7,  1'b0, 1'b1, 1'b1);
    vecs[24] = mk(1'b1, 1'b1, 1'b1, 2'b00, 6,  1'b0, 1'b1, 1'b1);
    vecs[25] = mk(1'b1, 1'b1, 1'b1, 2'b00, 1,  1'b0, 1'b0, 1'b0);
    vecs[26] = mk(1'b0, 1'b0, 1'b1, 2'b00, 10, 1'b0, 1'b0, 1'b0);

    rst          = 1'b1;
    power_on     = 1'b0;
    power_off    = 1'b0;
    manual_power = 1'b1;
    global_state = 2'b00;
    repeat (3) step();
    check("reset next_power", next_power, 1'b0);
    check("reset power_light", power_light, 1'b0);
    check("reset arming", arming, 1'b0);
    $display("[TB] reset np=%b pl=%b ar=%b", next_power, power_light, arming);
    rst = 1'b0;

    run_vectors(0, 17);

    // Bouncing button: level never stays put for 4 cycles.
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      power_on = ((i / 2) % 2) == 1;
      step();
      if (arming) seen = 1'b1;
    end
    power_on = 1'b0;
    repeat (6) step();
    check("bounce arming_seen", seen, 1'b0);
    check("bounce next_power", next_power, 1'b0);
    $display("[TB] bounce 50 cycles arming_seen=%b np=%b", seen, next_power);

    run_vectors(18, 26);

    // Reset in the middle of arming, with the button still held.
    power_on = 1'b1;
    repeat (10) step();
    check("pre_rst arming", arming, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_arming next_power", next_power, 1'b0);
    check("rst_arming power_light", power_light, 1'b0);
    check("rst_arming arming", arming, 1'b0);
    @(posedge sys_clk);
    #1 rst = 1'b0;
    repeat (6) step();
    check("post_rst debounce arming", arming, 1'b0);
    step();
    check("post_rst armed", arming, 1'b1);
    repeat (19) step();
    check("post_rst hold next_power", next_power, 1'b0);
    step();
    check("post_rst on next_power", next_power, 1'b1);
    $display("[TB] reset mid-arming then full re-arm np=%b ar=%b", next_power, arming);

    // Reset while on, button still held: power must need a full debounce + hold again.
    #2 rst = 1'b1;
    #1;
    check("rst_on next_power", next_power, 1'b0);
    check("rst_on power_light", power_light, 1'b0);
    @(posedge sys_clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (26) begin
      step();
      if (next_power) seen = 1'b1;
    end
    check("rst_on no early pulse", seen, 1'b0);
    step();
    check("rst_on repower", next_power, 1'b1);
    $display("[TB] reset in on, early_pulse=%b np=%b", seen, next_power);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/power_controller.md
POWER_CONTROLLER -- requirements
Module: power_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2_000_000, the number of stable sys_clk cycles before a button level is accepted (20 ms at 100 MHz).
REQ-002 Parameter HOLD_CYCLES, default 100_000_000, the number of cycles power_on must be held, debounced, to power up (1 s).
REQ-003 Parameter BLINK_CYCLES, default 12_500_000, the half-period of the power_light blink while arming.
REQ-004 Port sys_clk, input, 1 bit: the single clock, 100 MHz system clock; all state is on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port global_state, input, 2 bits: driving mode (00 manual, 01/10 semi-auto, 11 auto).
REQ-007 Port power_on, input, 1 bit: raw power-on button, asynchronous to sys_clk.
REQ-008 Port power_off, input, 1 bit: raw power-off button, asynchronous to sys_clk.
REQ-009 Port manual_power, input, 1 bit: manual-mode keep-alive; 0 means the manual driving logic requests engine stop (stall).
REQ-010 Port next_power, output, 1 bit: registered engine power level consumed by the device top.
REQ-011 Port power_light, output, 1 bit: registered power indicator LED.
REQ-012 Port arming, output, 1 bit: high while a power-on hold is in progress.

Function
REQ-013 Pass power_on and power_off each through a 2-flop synchronizer before any other use.
REQ-014 Debounce each synchronized button with its own counter: the accepted level changes only after the raw level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count at 0.
REQ-015 Implement the FSM with the states OFF, ARMING, ON and WAIT_RELEASE, encoded as 2 bits.
REQ-016 OFF: when the debounced power_on is 1 and the debounced power_off is 0, go to ARMING and clear the hold counter.
REQ-017 ARMING: increment the hold counter each cycle; when it reaches HOLD_CYCLES-1, go to ON.
REQ-018 ARMING: if power_on drops before the hold completes, return to OFF with no power change.
REQ-019 ON: a debounced power_off rising edge goes to WAIT_RELEASE.
REQ-020 ON: manual_power==0 while global_state==00 goes to WAIT_RELEASE.
REQ-021 ON: manual_power is ignored in every other global_state.
REQ-022 WAIT_RELEASE: go to OFF only when the debounced power_on is 0, so a held button cannot re-arm.
REQ-023 next_power is 1 exactly in state ON; it updates on the clock edge that enters or leaves ON, with latency 1 cycle from the FSM decision.
REQ-024 power_off has priority over power_on in every state; if both are debounced high in ARMING, go to WAIT_RELEASE.
REQ-025 The hold counter is 27 bits minimum and saturates, never wrapping.
REQ-026 Blink counter: 24 bits minimum, runs only in ARMING, and clears on exit.
REQ-027 power_light is 1 in ON, 0 in OFF and WAIT_RELEASE, and in ARMING starts at 1 and toggles every BLINK_CYCLES.
REQ-028 arming is 1 exactly in ARMING.
REQ-029 A global_state change never alters the FSM state by itself.
REQ-030 Any unused FSM encoding shall transition to OFF.

Reset
REQ-031 While rst=1, asynchronously force the state to OFF; clear all synchronizer, debounce, hold and blink registers; drive next_power=0, power_light=0 and arming=0.
REQ-032 Reset asserted mid-ARMING or in ON shall drop next_power within the same cycle it asserts, with no further pulse after release.
REQ-033 After rst deasserts, a power_on already held shall start a fresh debounce before arming.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, BLINK_CYCLES=3)
REQ-034 Hold power_on for 40 cycles -> arming rises about 6 cycles after the press; next_power=1 and power_light=1 about 20 cycles later; arming=0.
REQ-035 Press power_on for 10 cycles, then release -> next_power stays 0 and the state returns to OFF; power_light toggled with period 6 during ARMING.
REQ-036 In ON with global_state=00, pulse manual_power=0 for 1 cycle -> next_power=0 on the next edge; in ON with global_state=11, the same pulse -> next_power stays 1.
REQ-037 In ON, hold power_on high and press power_off -> next_power=0; the FSM stays in WAIT_RELEASE until power_on is released, with no re-power.
REQ-038 Toggle power_on every 2 cycles for 50 cycles (bounce) -> arming never asserts.
REQ-039 Assert rst for 1 cycle midway through ARMING and in ON -> all outputs 0 immediately; power-up then requires a full debounce plus hold.
